// File: rtl/vga_timing_pkg.sv
// Shared timing types, standard mode constants and the helper that turns
// porch/sync/active lengths into the limits an axis counter needs.
package vga_timing_pkg;

    // One axis of a video mode, all lengths in pixels (horizontal) or lines (vertical)
    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } mode_t;

    // Derived limits: sync is active for sync_start <= pos < sync_end
    typedef struct packed {
        int total;
        int sync_start;
        int sync_end;
    } axis_limits_t;

    localparam mode_t MODE_640X480_60 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
    localparam mode_t MODE_800X600_72 = '{h: '{800, 56, 120, 64}, v: '{600, 37, 6, 23}};

    function automatic axis_limits_t axis_limits(input int active, input int fp,
                                                 input int sync, input int bp);
        axis_limits_t l;
        l.total      = active + fp + sync + bp;
        l.sync_start = active + fp;
        l.sync_end   = active + fp + sync;
        return l;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with terminal count and registered sync decode.
// clr parks the axis at 0 with sync inactive; ld presents position 0 decoded;
// inc advances with wrap at TOTAL-1. cnt_nxt exposes the value being loaded so
// the parent can register its own decodes in the same cycle.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = 640,
    parameter int FP       = 16,
    parameter int SYNC     = 96,
    parameter int BP       = 48,
    parameter bit SYNC_POL = 1'b0,
    parameter int W        = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         tc,
    output logic         sync
);

    localparam axis_limits_t LIM     = axis_limits(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST    = W'(LIM.total - 1);
    localparam logic [W-1:0] SYNC_LO = W'(LIM.sync_start);
    // sync_end may equal 2^W, so compare one bit wider
    localparam logic [W:0]   SYNC_HI = (W+1)'(LIM.sync_end);

    logic in_win;

    assign tc = (cnt == LAST);

    // Next position: park/load go to 0, increment wraps at the terminal count
    always_comb begin
        cnt_nxt = cnt;
        if (clr || ld) begin
            cnt_nxt = '0;
        end else if (inc) begin
            cnt_nxt = tc ? '0 : cnt + 1'b1;
        end
    end

    assign in_win = (cnt_nxt >= SYNC_LO) && ({1'b0, cnt_nxt} < SYNC_HI);

    // Position and sync level are registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sync <= ~SYNC_POL;
        end else if (clr) begin
            cnt  <= '0;
            sync <= ~SYNC_POL;
        end else if (ld || inc) begin
            cnt  <= cnt_nxt;
            sync <= in_win ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, data-enable, coordinates and line/frame strobes,
// all registered on the same edge. Optional fetch-ahead outputs are built when
// VGA_TIMING_LOOKAHEAD_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
`ifdef VGA_TIMING_LOOKAHEAD_EN
    parameter int LOOKAHEAD = 2,
`endif
    parameter int X_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int Y_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_en,
    input  logic           en,
    output logic           h_sync,
    output logic           v_sync,
    output logic           valid,
    output logic [X_W-1:0] x_counter,
    output logic [Y_W-1:0] y_counter,
    output logic           line_start,
    output logic           frame_start
`ifdef VGA_TIMING_LOOKAHEAD_EN
    ,
    output logic [X_W-1:0] fetch_x,
    output logic [Y_W-1:0] fetch_y,
    output logic           fetch_valid
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [X_W-1:0] H_ACT_C = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] V_ACT_C = Y_W'(V_ACTIVE);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        X_W < 1 || Y_W < 1 || H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_params
        $error("vga_timing_gen: illegal timing parameter set");
    end

    logic           running;
    logic           step, ld, h_inc, v_inc;
    logic           h_tc, v_tc;
    logic [X_W-1:0] x_nxt;
    logic [Y_W-1:0] y_nxt;

    // A qualified step either starts a fresh frame at (0,0) or advances the raster
    assign step  = en && pix_en;
    assign ld    = step && !running;
    assign h_inc = step && running;
    assign v_inc = h_inc && h_tc;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .SYNC_POL(HSYNC_POL != 0), .W(X_W)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .clr(!en), .ld(ld), .inc(h_inc),
        .cnt(x_counter), .cnt_nxt(x_nxt), .tc(h_tc), .sync(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .SYNC_POL(VSYNC_POL != 0), .W(Y_W)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .clr(!en), .ld(ld), .inc(v_inc),
        .cnt(y_counter), .cnt_nxt(y_nxt), .tc(v_tc), .sync(v_sync)
    );

    // Run flag, data-enable and strobes, decoded from the position being loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            valid       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            running     <= 1'b0;
            valid       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            running     <= 1'b1;
            valid       <= (x_nxt < H_ACT_C) && (y_nxt < V_ACT_C);
            line_start  <= !running || h_tc;
            frame_start <= !running || (h_tc && v_tc);
        end
    end

`ifdef VGA_TIMING_LOOKAHEAD_EN
    localparam int F_TOTAL = H_TOTAL * V_TOTAL;
    localparam int LA_POS  = LOOKAHEAD % F_TOTAL;
    localparam logic [X_W-1:0] LA_X   = X_W'(LA_POS % H_TOTAL);
    localparam logic [Y_W-1:0] LA_Y   = Y_W'(LA_POS / H_TOTAL);
    localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);

    if (LOOKAHEAD < 1 || LOOKAHEAD > 8) begin : g_bad_lookahead
        $error("vga_timing_gen: LOOKAHEAD must be 1..8");
    end

    logic [X_W-1:0] fx_nxt;
    logic [Y_W-1:0] fy_nxt;

    // Fetch position runs LOOKAHEAD steps ahead; it already sits there while parked
    always_comb begin
        fx_nxt = fetch_x;
        fy_nxt = fetch_y;
        if (running) begin
            fx_nxt = (fetch_x == H_LAST) ? '0 : fetch_x + 1'b1;
            if (fetch_x == H_LAST) begin
                fy_nxt = (fetch_y == V_LAST) ? '0 : fetch_y + 1'b1;
            end
        end
    end

    // Fetch registers follow the same park/hold rules as the presented position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_x     <= LA_X;
            fetch_y     <= LA_Y;
            fetch_valid <= 1'b0;
        end else if (!en) begin
            fetch_x     <= LA_X;
            fetch_y     <= LA_Y;
            fetch_valid <= 1'b0;
        end else if (pix_en) begin
            fetch_x     <= fx_nxt;
            fetch_y     <= fy_nxt;
            fetch_valid <= (fx_nxt < H_ACT_C) && (fy_nxt < V_ACT_C);
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two instances (a small custom mode with
// active-low syncs and the 800x600@72 package mode with active-high syncs) share
// one stimulus stream; a raster-index reference model predicts each cycle.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    // Mode A: small raster so whole frames fit in a short run
    localparam int A_HA = 16, A_HF = 3, A_HS = 4, A_HB = 5;
    localparam int A_VA = 6, A_VF = 2, A_VS = 2, A_VB = 3;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
    localparam int A_XW = $clog2(A_HT);
    localparam int A_YW = $clog2(A_VT);
    // Mode B: 800x600@72 written out independently of the package
    localparam int B_HA = 800, B_HF = 56, B_HS = 120, B_HB = 64;
    localparam int B_VA = 600, B_VF = 37, B_VS = 6, B_VB = 23;
    localparam int B_HT = 1040;
    localparam int B_VT = 666;
    localparam int B_XW = 11;
    localparam int B_YW = 10;
    localparam int LA = 2;

    typedef struct {
        int x;
        int y;
        bit valid;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        int fx;
        int fy;
        bit fv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, en, pix_en;

    logic            a_hs, a_vs, a_valid, a_ls, a_fs;
    logic [A_XW-1:0] a_x;
    logic [A_YW-1:0] a_y;
    logic            b_hs, b_vs, b_valid, b_ls, b_fs;
    logic [B_XW-1:0] b_x;
    logic [B_YW-1:0] b_y;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [A_XW-1:0] a_fx;
    logic [A_YW-1:0] a_fy;
    logic            a_fv;
    logic [B_XW-1:0] b_fx;
    logic [B_YW-1:0] b_fy;
    logic            b_fv;
`endif

    int   total = 0;
    int   bad   = 0;
    bit   chk   = 1'b0;
    bit   live  = 1'b0;
    int   pa    = 0;
    int   pb    = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .HSYNC_POL(0), .VSYNC_POL(0),
`ifdef VGA_TIMING_LOOKAHEAD_EN
        .LOOKAHEAD(LA),
`endif
        .X_W(A_XW), .Y_W(A_YW)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .en(en),
        .h_sync(a_hs), .v_sync(a_vs), .valid(a_valid),
        .x_counter(a_x), .y_counter(a_y),
        .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_LOOKAHEAD_EN
        , .fetch_x(a_fx), .fetch_y(a_fy), .fetch_valid(a_fv)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(MODE_800X600_72.h.active), .H_FP(MODE_800X600_72.h.fp),
        .H_SYNC(MODE_800X600_72.h.sync), .H_BP(MODE_800X600_72.h.bp),
        .V_ACTIVE(MODE_800X600_72.v.active), .V_FP(MODE_800X600_72.v.fp),
        .V_SYNC(MODE_800X600_72.v.sync), .V_BP(MODE_800X600_72.v.bp),
        .HSYNC_POL(1), .VSYNC_POL(1),
`ifdef VGA_TIMING_LOOKAHEAD_EN
        .LOOKAHEAD(LA),
`endif
        .X_W(B_XW), .Y_W(B_YW)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .en(en),
        .h_sync(b_hs), .v_sync(b_vs), .valid(b_valid),
        .x_counter(b_x), .y_counter(b_y),
        .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_LOOKAHEAD_EN
        , .fetch_x(b_fx), .fetch_y(b_fy), .fetch_valid(b_fv)
`endif
    );

    // Reference: the raster is a linear index p into the frame; everything is
    // derived from p with div/mod, plus a flag saying whether a frame is live.
    function automatic exp_t ref_out(input int ha, input int hf, input int hs, input int hb,
                                     input int va, input int vf, input int vs, input int vb,
                                     input bit hp, input bit vp, input bit lv, input int p);
        exp_t e;
        int ht, ft, q;
        ht = ha + hf + hs + hb;
        ft = ht * (va + vf + vs + vb);
        e.x     = p % ht;
        e.y     = p / ht;
        e.valid = lv && (e.x < ha) && (e.y < va);
        e.hs    = (lv && e.x >= ha + hf && e.x < ha + hf + hs) ? hp : !hp;
        e.vs    = (lv && e.y >= va + vf && e.y < va + vf + vs) ? vp : !vp;
        e.ls    = lv && (e.x == 0);
        e.fs    = lv && (p == 0);
        q       = (p + LA) % ft;
        e.fx    = q % ht;
        e.fy    = q / ht;
        e.fv    = lv && (e.fx < ha) && (e.fy < va);
        return e;
    endfunction

    function automatic exp_t exp_a();
        return ref_out(A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0, 1'b0, live, pa);
    endfunction

    function automatic exp_t exp_b();
        return ref_out(B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, 1'b1, live, pb);
    endfunction

    function automatic exp_t samp_a();
        exp_t e;
        e.x = int'(a_x); e.y = int'(a_y); e.valid = a_valid;
        e.hs = a_hs; e.vs = a_vs; e.ls = a_ls; e.fs = a_fs;
`ifdef VGA_TIMING_LOOKAHEAD_EN
        e.fx = int'(a_fx); e.fy = int'(a_fy); e.fv = a_fv;
`else
        e.fx = 0; e.fy = 0; e.fv = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t samp_b();
        exp_t e;
        e.x = int'(b_x); e.y = int'(b_y); e.valid = b_valid;
        e.hs = b_hs; e.vs = b_vs; e.ls = b_ls; e.fs = b_fs;
`ifdef VGA_TIMING_LOOKAHEAD_EN
        e.fx = int'(b_fx); e.fy = int'(b_fy); e.fv = b_fv;
`else
        e.fx = 0; e.fy = 0; e.fv = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string nm, input exp_t g, input exp_t e);
        bit ok;
        ok = (g.x == e.x) && (g.y == e.y) && (g.valid == e.valid) && (g.hs == e.hs) &&
             (g.vs == e.vs) && (g.ls == e.ls) && (g.fs == e.fs);
`ifdef VGA_TIMING_LOOKAHEAD_EN
        ok = ok && (g.fx == e.fx) && (g.fy == e.fy) && (g.fv == e.fv);
`endif
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s t=%0t: got x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b fx=%0d fy=%0d fv=%0b | required x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b fx=%0d fy=%0d fv=%0b",
                     nm, $time, g.x, g.y, g.valid, g.hs, g.vs, g.ls, g.fs, g.fx, g.fy, g.fv,
                     e.x, e.y, e.valid, e.hs, e.vs, e.ls, e.fs, e.fx, e.fy, e.fv);
        end
    endtask

    // Apply inputs for the coming edge, advance the model, queue the prediction
    task automatic drive(input bit e, input bit pe);
        en     = e;
        pix_en = pe;
        if (!e) begin
            live = 1'b0; pa = 0; pb = 0;
        end else if (pe) begin
            if (!live) begin
                live = 1'b1; pa = 0; pb = 0;
            end else begin
                pa = (pa + 1) % (A_HT * A_VT);
                pb = (pb + 1) % (B_HT * B_VT);
            end
        end
        qa.push_back(exp_a());
        qb.push_back(exp_b());
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string nm);
        live = 1'b0; pa = 0; pb = 0;
        check({nm, "_a"}, samp_a(), exp_a());
        check({nm, "_b"}, samp_b(), exp_b());
    endtask

    // Monitor: pops one prediction per DUT after every edge while checking is on
    initial begin
        exp_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (chk) begin
                if (qa.size() == 0 || qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty t=%0t: got qa=%0d qb=%0d entries, required 1 each",
                             $time, qa.size(), qb.size());
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    check("raster_a", samp_a(), ea);
                    check("raster_b", samp_b(), eb);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int guard;
        rst_n = 1'b0; en = 1'b0; pix_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk = 1'b1;

        // Parked with en low, then continuous run across two full frames of A
        repeat (3) drive(1'b0, 1'b1);
        repeat (2 * A_HT * A_VT + 40) drive(1'b1, 1'b1);

        // Clock-enable every other cycle
        for (int i = 0; i < 400; i++) drive(1'b1, (i % 2) == 0);

        // Drop en while presenting (20,4) of A, hold low 5 cycles, restart
        guard = 0;
        while (!(live && pa == 4 * A_HT + 20) && guard < 2 * A_HT * A_VT) begin
            drive(1'b1, 1'b1);
            guard++;
        end
        repeat (5) drive(1'b0, 1'($urandom_range(1)));
        repeat (80) drive(1'b1, 1'b1);

        // Randomised enables
        repeat (2500) drive($urandom_range(99) < 96, $urandom_range(99) < 70);

        // Asynchronous reset mid-frame, then run again
        repeat (57) drive(1'b1, 1'b1);
        chk = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk = 1'b1;
        repeat (200) drive(1'b1, 1'b1);
        chk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the video output path. Produces horizontal and vertical sync, data-enable, pixel coordinates, and line/frame strobes for any mode that can be described by porch, sync, and active lengths. Sits between the pixel-clock domain's clock-enable source and the framebuffer read / colour-output stage. All outputs for a given raster position are registered together and change on the same edge, so there is no skew between coordinates, sync, and data-enable.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HSYNC_POL`, 0: active level of `h_sync` (0 = active-low)
- `VSYNC_POL`, 0: active level of `v_sync` (0 = active-low)
- `X_W`, `$clog2(H_TOTAL)`: width of `x_counter`
- `Y_W`, `$clog2(V_TOTAL)`: width of `y_counter`

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `pix_en`  in  1  pixel clock-enable; the raster advances only on `clk` edges where this is 1
- `en`  in  1  run enable; 0 parks the raster at (0,0)
- `h_sync`  out  1  horizontal sync, level set by `HSYNC_POL`
- `v_sync`  out  1  vertical sync, level set by `VSYNC_POL`
- `valid`  out  1  data-enable, 1 for visible pixels only
- `x_counter`  out  `X_W`  current column
- `y_counter`  out  `Y_W`  current line
- `line_start`  out  1  one-cycle pulse at x = 0
- `frame_start`  out  1  one-cycle pulse at (0,0)

## Operation
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is defined the same way from the V_ parameters.
- Advance: x increments on every qualified step. When x = H_TOTAL−1, x wraps to 0 and y increments. When y = V_TOTAL−1 and x wraps, y wraps to 0.
- A qualified step is a `clk` edge with `en`=1 and `pix_en`=1. If `pix_en`=0, the whole state holds, including both strobes.
- `valid` = (x < H_ACTIVE) and (y < V_ACTIVE).
- `h_sync` is active for H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, independent of y.
- `v_sync` is active for whole lines V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC.
- `line_start` = (x == 0). `frame_start` = (x == 0 and y == 0). Each strobe is high for exactly one qualified step.
- `en` = 0: on the next `clk` edge, the position is forced to (0,0), `valid`/`line_start`/`frame_start` go to 0, and both syncs go inactive. This is independent of `pix_en`.
- Restart after `en` rises: the first qualified step presents (0,0) with `frame_start`=1. A frame always starts clean.
- Arithmetic: counters use unsigned compare-and-wrap only. Terminal counts are constants derived from the parameters. Values ≥ total are never reached.
- Legality: every parameter is ≥ 1; H_TOTAL ≤ 2^X_W; V_TOTAL ≤ 2^Y_W. An illegal set is an elaboration error.

## Timing
- Reset state (asynchronous, while `rst_n`=0): `x_counter`=0, `y_counter`=0, `valid`=0, `line_start`=0, `frame_start`=0, `h_sync`=~HSYNC_POL, `v_sync`=~VSYNC_POL.
- First qualified step after reset release presents (0,0) with `frame_start`=1 and `valid`=1.
- All outputs are flops. They describe the position presented in the same cycle, with zero relative latency and no combinational input-to-output path.
- Reset mid-frame aborts immediately; no partial-line recovery.

## Configuration
- `VGA_TIMING_LOOKAHEAD_EN` defined:
  - Adds parameter `LOOKAHEAD` (default 2, legal range 1..8).
  - Adds outputs `fetch_x` (`X_W`), `fetch_y` (`Y_W`), and `fetch_valid` (1).
  - These give the position, and its data-enable, that will be presented `LOOKAHEAD` qualified steps later. They wrap correctly across line and frame ends.
  - `fetch_*` obey the same `en`/reset park rules, parking at position LOOKAHEAD along the raster.
  - Purpose: lets a registered framebuffer read issue early.
- Undefined: the extra ports and parameter are absent and behaviour is otherwise identical.

## Structure
- Package `vga_timing_pkg`:
  - Mode constants for 640x480@60 (the defaults) and 800x600@72.
  - Function computing total and sync start/end from porch values.
  - Shared typedef for a timing-parameter struct.
- Sub-module `vga_axis_counter`: one wrap counter with a terminal-count output and a sync-window decode. It is instantiated once for the horizontal axis and once for the vertical axis, with the vertical instance stepped by the horizontal terminal count.

## Test plan
- Reset, then `en`=1 with `pix_en`=1 every cycle, defaults → `frame_start` at cycle 1; `h_sync` low exactly for x=656..751; `line_start` period 800; frame period 420000 cycles.
- `pix_en` toggling 1,0,1,0 → all outputs hold on off cycles; `h_sync` width = 192 clk cycles; `frame_start` width = 2 clk cycles.
- `en` dropped at (700,300), raised 5 cycles later → next qualified step shows (0,0) with `frame_start`=1; syncs stay inactive while parked.
- Vertical boundary → `v_sync` low for lines 490–491 only; `valid`=0 for y ≥ 480 and for x ≥ 640.
- `HSYNC_POL`=1, `VSYNC_POL`=1, 800x600@72 package mode → sync active-high, H_TOTAL 1040, V_TOTAL 666.
- `VGA_TIMING_LOOKAHEAD_EN` with `LOOKAHEAD`=2 → `fetch_x` = 0 while presenting x=798; `fetch_y` = 0 while presenting (798,524).
